// File: rtl/dram_wb_receiver.sv
// Writeback byte-stream sink: packs bytes into words, buffers them in a
// small FIFO and writes them to the output DRAM at sequential addresses.
module dram_wb_receiver #(
    parameter int DATA_WID   = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = 1024,
    parameter int ADDR_W     = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_wen,
    input  logic [DATA_WID-1:0]        in_data,
    output logic                       dram_wr_valid,
    input  logic                       dram_wr_ready,
    output logic [ADDR_W-1:0]          dram_wr_addr,
    output logic [DATA_WID*PACK-1:0]   dram_wr_data,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       err_drop
);

    localparam int WW = DATA_WID * PACK;
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN) + 1;

    localparam logic [CW-1:0]     LAST_BYTE = CW'(FRAME_LEN);
    localparam logic [LW-1:0]     LAST_LANE = LW'(PACK - 1);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A    =
        ADDR_W'(BASE_ADDR + FRAME_LEN / PACK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   busy_q, done_q;

    logic [LW-1:0]     lane_q, lane_d, idx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     pack_q, pack_d;
    logic [WW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic accept, discard, word_done, last_byte;
    logic empty, full, pop, push, drop;

    always_comb begin
        accept    = in_wen && (state_q == IDLE || state_q == RUN);
        discard   = in_wen && (state_q == FLUSH || state_q == DONE);
        // A frame always starts on lane 0, whatever the lane counter holds.
        idx       = (state_q == IDLE) ? '0 : lane_q;
        word_done = accept && (idx == LAST_LANE);

        pack_d = pack_q;
        lane_d = lane_q;
        cnt_d  = cnt_q;
        if (accept) begin
            pack_d[int'(idx) * DATA_WID +: DATA_WID] = in_data;
            lane_d = word_done ? '0 : idx + LW'(1);
            cnt_d  = ((state_q == IDLE) ? '0 : cnt_q) + CW'(1);
        end
        last_byte = accept && (cnt_d == LAST_BYTE);

        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW])
             && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop   = !empty && dram_wr_ready;
        push  = word_done && (!full || pop);
        drop  = word_done && full && !pop;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        addr_d = addr_q;
        if (push) wptr_d = wptr_q + (AW+1)'(1);
        if (pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
            addr_d = (addr_q == LAST_A) ? BASE_A : addr_q + ADDR_W'(1);
        end
        err_d = err_q || drop || discard;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept ? (last_byte ? FLUSH : RUN) : IDLE;
            RUN:     state_d = last_byte ? FLUSH : RUN;
            FLUSH:   state_d = (wptr_d == rptr_d) ? DONE : FLUSH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lane_q <= '0;
            cnt_q  <= '0;
            pack_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            addr_q <= BASE_A;
            err_q  <= 1'b0;
        end else begin
            lane_q <= lane_d;
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    // On push-while-full-with-pop the written slot is the one being read out.
    always_ff @(posedge clk) begin
        if (reset && push) mem_q[wptr_q[AW-1:0]] <= pack_d;
    end

    assign dram_wr_valid = !empty;
    assign dram_wr_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign dram_wr_addr  = addr_q;
    assign frame_done    = done_q;
    assign busy          = busy_q;
    assign err_drop      = err_q;

endmodule

// File: tb/tb_dram_wb_receiver.sv
// Bench for dram_wb_receiver: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_dram_wb_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_wen = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        dram_wr_ready = 1'b0;
    logic        dram_wr_valid;
    logic [7:0]  dram_wr_addr;
    logic [31:0] dram_wr_data;
    logic        frame_done;
    logic        busy;
    logic        err_drop;

    dram_wb_receiver dut (
        .clk           (clk),
        .reset         (reset),
        .in_wen        (in_wen),
        .in_data       (in_data),
        .dram_wr_valid (dram_wr_valid),
        .dram_wr_ready (dram_wr_ready),
        .dram_wr_addr  (dram_wr_addr),
        .dram_wr_data  (dram_wr_data),
        .frame_done    (frame_done),
        .busy          (busy),
        .err_drop      (err_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done pulse.
    logic [7:0]  part[$];
    logic [31:0] wq[$];
    int          m_addr, m_nb, ph;
    bit          m_err;

    logic [7:0]  obs_a[$];
    logic [31:0] obs_d[$];
    int          cyc = 0, vcyc, nd, last_acc, done_at;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_update();
        bit          pop, acc, disc, push;
        logic [31:0] w;
        int          sz;
        if (!reset) begin
            part.delete();
            wq.delete();
            m_addr = 0;
            m_nb   = 0;
            ph     = 0;
            m_err  = 0;
            return;
        end
        pop  = (wq.size() > 0) && dram_wr_ready;
        acc  = in_wen && (ph == 0 || ph == 1);
        disc = in_wen && (ph >= 2);
        if (disc) m_err = 1;
        push = 0;
        w    = '0;
        if (acc) begin
            if (ph == 0) m_nb = 0;
            m_nb++;
            part.push_back(in_data);
            if (part.size() == 4) begin
                w = {part[3], part[2], part[1], part[0]};
                part.delete();
                push = 1;
            end
        end
        sz = wq.size();
        if (pop) begin
            void'(wq.pop_front());
            m_addr = (m_addr + 1) % 256;
        end
        if (push) begin
            if (sz == 4 && !pop) m_err = 1;
            else wq.push_back(w);
        end
        case (ph)
            0: if (acc) ph = (m_nb == 1024) ? 2 : 1;
            1: if (acc && m_nb == 1024) ph = 2;
            2: if (wq.size() == 0) ph = 3;
            default: ph = 0;
        endcase
    endtask

    task automatic check_all();
        if (frame_done === 1'b1) begin
            nd++;
            done_at = cyc;
        end
        chk("valid", dram_wr_valid, wq.size() != 0);
        chk("data", dram_wr_data, (wq.size() != 0) ? wq[0] : 32'h0);
        chk("addr", dram_wr_addr, m_addr);
        chk("frame_done", frame_done, ph == 3);
        chk("busy", busy, ph != 0);
        chk("err_drop", err_drop, m_err);
        chk("done_vs_valid", frame_done && dram_wr_valid, 0);
    endtask

    task automatic step();
        cyc++;
        if (dram_wr_valid === 1'b1) vcyc++;
        if (reset && dram_wr_valid === 1'b1 && dram_wr_ready) begin
            obs_a.push_back(dram_wr_addr);
            obs_d.push_back(dram_wr_data);
            last_acc = cyc;
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit wen, input logic [7:0] d, input bit rdy);
        in_wen        = wen;
        in_data       = d;
        dram_wr_ready = rdy;
        step();
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_d.delete();
        vcyc     = 0;
        nd       = 0;
        last_acc = -1;
        done_at  = -2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        reset = 1'b1;
        clear_obs();
    endtask

    task automatic wait_idle(input int maxc, input bit tog);
        for (int i = 0; i < maxc; i++) begin
            if (!busy && !dram_wr_valid) break;
            drive(0, 8'h00, tog ? cyc[0] : 1'b1);
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        // Reset state and a single word with ready high.
        do_reset();
        chk("rst_valid", dram_wr_valid, 0);
        chk("rst_data", dram_wr_data, 0);
        chk("rst_addr", dram_wr_addr, 0);
        for (int i = 0; i < 4; i++) drive(1, 8'(i + 1), 1);
        for (int i = 0; i < 4; i++) drive(0, 8'h00, 1);
        chk("s1_nwr", obs_a.size(), 1);
        chk("s1_addr", obs_a[0], 0);
        chk("s1_data", obs_d[0], 32'h04030201);
        chk("s1_vcyc", vcyc, 1);

        // Signed extremes held under back-pressure.
        do_reset();
        drive(1, 8'hFF, 0);
        drive(1, 8'h80, 0);
        drive(1, 8'h7F, 0);
        drive(1, 8'h00, 0);
        for (int i = 0; i < 5; i++) drive(0, 8'h00, 0);
        chk("s2_held", obs_a.size(), 0);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 1);
        chk("s2_nwr", obs_a.size(), 1);
        chk("s2_data", obs_d[0], 32'h007F80FF);
        chk("s2_addr", obs_a[0], 0);

        // Overflow: 5th word dropped.
        do_reset();
        for (int i = 0; i < 20; i++) drive(1, 8'(i), 0);
        chk("s3_err", err_drop, 1);
        for (int i = 0; i < 8; i++) drive(0, 8'h00, 1);
        chk("s3_nwr", obs_a.size(), 4);
        for (int j = 0; j < 4; j++) begin
            chk("s3_addr", obs_a[j], j);
            chk("s3_data", obs_d[j],
                {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
        end

        // Full frame with ready toggling, then next frame restarts at 0.
        do_reset();
        for (int i = 0; i < 1024; i++) drive(1, 8'($urandom), i % 2 == 0);
        wait_idle(600, 1);
        chk("s4_nwr", obs_a.size(), 256);
        for (int j = 0; j < 256; j++) chk("s4_addr_seq", obs_a[j], j);
        chk("s4_ndone", nd, 1);
        chk("s4_done_lat", done_at - last_acc, 0);
        clear_obs();
        for (int i = 0; i < 4; i++) drive(1, 8'($urandom), 1);
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 1);
        chk("s4_next_nwr", obs_a.size(), 1);
        chk("s4_next_addr", obs_a[0], 0);

        // Reset mid-word: partial data never written.
        do_reset();
        for (int i = 0; i < 14; i++) drive(1, 8'(i), 1);
        reset = 1'b0;
        drive(0, 8'h00, 1);
        reset = 1'b1;
        clear_obs();
        chk("s5_rst_valid", dram_wr_valid, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_addr", dram_wr_addr, 0);
        for (int i = 0; i < 4; i++) drive(1, 8'(8'hA0 + i), 1);
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 1);
        chk("s5_nwr", obs_a.size(), 1);
        chk("s5_addr", obs_a[0], 0);
        chk("s5_data", obs_d[0], 32'hA3A2A1A0);

        // Bytes arriving while flushing are discarded.
        do_reset();
        for (int i = 0; i < 1024; i++) drive(1, 8'($urandom), 1);
        chk("s6_err_pre", err_drop, 0);
        for (int i = 0; i < 3; i++) drive(1, 8'hAA, 0);
        chk("s6_err", err_drop, 1);
        chk("s6_busy", busy, 1);
        wait_idle(50, 0);
        chk("s6_nwr", obs_a.size(), 256);
        chk("s6_ndone", nd, 1);

        // Random traffic over several frames.
        do_reset();
        for (int i = 0; i < 4500; i++)
            drive($urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) != 0);
        for (int i = 0; i < 12; i++) drive(0, 8'h00, 1);
        chk("s7_drained", dram_wr_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_wb_receiver.md
Name: dram_wb_receiver

Overview:
- Sink end of the writeback byte stream (`DRAM_in3_WEN` / `DRAM_in3_Data`) produced by the writeback controller.
- Packs signed 8-bit ReLU outputs into 32-bit words and buffers them in a small FIFO.
- Issues valid/ready word writes to the output DRAM at sequential addresses.
- Tracks frame completion: FRAME_LEN bytes per frame, 1024 by default.

Parameters:
- DATA_WID, 8, width of one input byte.
- PACK, 4, bytes per output word; word width = DATA_WID*PACK.
- FIFO_DEPTH, 4, number of packed-word entries; power of 2.
- FRAME_LEN, 1024, bytes per frame; must be a multiple of PACK.
- ADDR_W, 8, DRAM word address width; must satisfy 2^ADDR_W >= FRAME_LEN/PACK.
- BASE_ADDR, 0, word address of the first word of each frame.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset.
- in_wen, input, 1, byte strobe from the writeback controller.
- in_data, input, DATA_WID, signed byte; valid when in_wen=1.
- dram_wr_valid, output, 1, word write request.
- dram_wr_ready, input, 1, DRAM accepts the word this cycle.
- dram_wr_addr, output, ADDR_W, word address.
- dram_wr_data, output, DATA_WID*PACK, packed word.
- frame_done, output, 1, one-cycle pulse after the last word of a frame is accepted.
- busy, output, 1, high in every state except IDLE.
- err_drop, output, 1, sticky flag: a byte or word was discarded.

Behaviour:
- Reset (reset=0 at posedge):
  - FIFO emptied, partial word discarded, all counters cleared, FSM to IDLE.
  - Outputs: dram_wr_valid=0, dram_wr_addr=BASE_ADDR, dram_wr_data=0, frame_done=0, busy=0, err_drop=0.
  - Applies mid-frame identically; no write is issued for partial data.
- Packing:
  - Byte k of a word (k = byte_cnt mod PACK) goes to bits [k*DATA_WID +: DATA_WID]. The first byte lands in [7:0].
  - On the PACK-th byte, the full word is pushed into the FIFO at that same clock edge.
  - dram_wr_valid can therefore assert at the earliest on the cycle after the edge that captured the last byte.
- FIFO:
  - Push on word completion; pop when dram_wr_valid && dram_wr_ready.
  - dram_wr_valid = FIFO not empty. dram_wr_data = FIFO head.
  - Data and address are held stable while valid && !ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - Push while full with no pop: the word is dropped, err_drop is set, and the address is not advanced for the dropped word.
- Address:
  - dram_wr_addr starts at BASE_ADDR and increments by 1 on each pop.
  - After the last word of a frame (word FRAME_LEN/PACK-1) it wraps to BASE_ADDR.
- Byte counter: width $clog2(FRAME_LEN)+1; counts accepted bytes; cleared on the IDLE->RUN transition.
- FSM (states IDLE, RUN, FLUSH, DONE):
  - IDLE: busy=0. When in_wen=1, the byte is accepted and the FSM goes to RUN.
  - RUN: accepts bytes. On acceptance of byte FRAME_LEN, go to FLUSH.
  - FLUSH: in_wen bytes are discarded and set err_drop. When the FIFO is empty (last pop done), go to DONE.
  - DONE: frame_done=1 for exactly this cycle. in_wen in this cycle is discarded and sets err_drop. Go to IDLE next cycle.
- frame_done is never asserted while dram_wr_valid=1.
- Signed data is passed through bit-exact; no saturation or sign extension.
- Unknown states decode to IDLE.

Test Plan:
- Bytes 0x01,0x02,0x03,0x04 on 4 consecutive cycles, ready=1 -> one write, addr=0x00, data=0x04030201, valid high for exactly 1 cycle.
- Bytes 0xFF,0x80,0x7F,0x00, ready held 0 for 5 cycles -> data=0x007F80FF and addr=0 held stable throughout; accepted on the first ready=1 cycle.
- ready=0, 20 bytes streamed back-to-back -> 4 words buffered, 5th word dropped, err_drop=1. After ready=1: exactly 4 writes at addr 0..3.
- Full 1024-byte frame with ready toggling 1/0 -> 256 writes at addr 0..255, frame_done pulses once, 1 cycle after the final accept, then busy=0. The next frame restarts at addr 0.
- reset=0 asserted after 2 bytes of word 3 of a frame -> no write for the partial data, all outputs reset. The next 4 bytes produce a word at addr 0.
- in_wen=1 during FLUSH -> byte discarded, err_drop=1, word count for the frame still 256, frame_done still pulses.
